aftab_csr_sequencer: RTL and testbench

AFTAB_CSR_SEQUENCER -- requirements
Module: aftab_CSR_sequencer

---
 rtl/aftab_csr_sequencer.sv | 103 ++++++++++
 tb/tb_aftab_csr_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_csr_sequencer.sv
// rtl/aftab_csr_sequencer.sv - Moore sequencer for trap-entry and mret CSR access steps
// Optional mtval write step enabled by defining AFTAB_MTVAL_WRITE_EN.
module aftab_csr_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       trapReq,
    input  logic       mretReq,
    input  logic       instrCsrReq,
    input  logic       csrReady,
    output logic [2:0] cntOutput,
    output logic       csrWrEn,
    output logic       csrRdEn,
    output logic [1:0] csrWrSrc,
    output logic       busy,
    output logic       trapDone,
    output logic       mretDone,
    output logic       instrGrant
);

    typedef enum logic [3:0] {
        IDLE, E_CAUSE, E_EPC, E_TVAL, E_STRD, E_STWR, E_VEC,
        M_STRD, M_STWR, M_EPC, T_DONE, M_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_d;
    logic       wr_d, rd_d, busy_d, tdone_d, mdone_d;
    logic [1:0] src_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trapReq)      state_d = E_CAUSE;
                else if (mretReq) state_d = M_STRD;
            end
            E_CAUSE: if (csrReady) state_d = E_EPC;
`ifdef AFTAB_MTVAL_WRITE_EN
            E_EPC:   if (csrReady) state_d = E_TVAL;
            E_TVAL:  if (csrReady) state_d = E_STRD;
`else
            E_EPC:   if (csrReady) state_d = E_STRD;
`endif
            E_STRD:  if (csrReady) state_d = E_STWR;
            E_STWR:  if (csrReady) state_d = E_VEC;
            E_VEC:   if (csrReady) state_d = T_DONE;
            M_STRD:  if (csrReady) state_d = M_STWR;
            M_STWR:  if (csrReady) state_d = M_EPC;
            M_EPC:   if (csrReady) state_d = M_DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track state_q exactly.
    always_comb begin
        cnt_d   = 3'b000;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        src_d   = 2'b00;
        busy_d  = (state_d != IDLE);
        tdone_d = (state_d == T_DONE);
        mdone_d = (state_d == M_DONE);
        case (state_d)
            E_CAUSE: begin cnt_d = 3'b001; wr_d = 1'b1; src_d = 2'b00; end
            E_EPC:   begin cnt_d = 3'b010; wr_d = 1'b1; src_d = 2'b01; end
`ifdef AFTAB_MTVAL_WRITE_EN
            E_TVAL:  begin cnt_d = 3'b111; wr_d = 1'b1; src_d = 2'b10; end
`endif
            E_STRD:  begin cnt_d = 3'b100; rd_d = 1'b1; end
            E_STWR:  begin cnt_d = 3'b100; wr_d = 1'b1; src_d = 2'b11; end
            E_VEC:   begin cnt_d = 3'b011; rd_d = 1'b1; end
            M_STRD:  begin cnt_d = 3'b100; rd_d = 1'b1; end
            M_STWR:  begin cnt_d = 3'b100; wr_d = 1'b1; src_d = 2'b11; end
            M_EPC:   begin cnt_d = 3'b010; rd_d = 1'b1; end
            default: begin cnt_d = 3'b000; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cntOutput <= 3'b000;
            csrWrEn   <= 1'b0;
            csrRdEn   <= 1'b0;
            csrWrSrc  <= 2'b00;
            busy      <= 1'b0;
            trapDone  <= 1'b0;
            mretDone  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cntOutput <= cnt_d;
            csrWrEn   <= wr_d;
            csrRdEn   <= rd_d;
            csrWrSrc  <= src_d;
            busy      <= busy_d;
            trapDone  <= tdone_d;
            mretDone  <= mdone_d;
        end
    end

    assign instrGrant = (state_q == IDLE) & ~trapReq & ~mretReq & instrCsrReq;

endmodule

// File: tb/tb_aftab_csr_sequencer.sv
// tb/tb_aftab_csr_sequencer.sv - vector table, corner sequences and random run against a step-list model
module tb_aftab_csr_sequencer;

    logic       clk = 1'b0;
    logic       rst, trapReq, mretReq, instrCsrReq, csrReady;
    logic [2:0] cntOutput;
    logic       csrWrEn, csrRdEn, busy, trapDone, mretDone, instrGrant;
    logic [1:0] csrWrSrc;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    aftab_csr_sequencer dut (
        .clk(clk), .rst(rst), .trapReq(trapReq), .mretReq(mretReq),
        .instrCsrReq(instrCsrReq), .csrReady(csrReady), .cntOutput(cntOutput),
        .csrWrEn(csrWrEn), .csrRdEn(csrRdEn), .csrWrSrc(csrWrSrc), .busy(busy),
        .trapDone(trapDone), .mretDone(mretDone), .instrGrant(instrGrant)
    );

    typedef struct {
        logic [2:0] cnt;
        logic       wr, rd;
        logic [1:0] src;
        logic       td, md;
    } step_t;

    typedef struct {
        logic        rst, trap, mret, instr, ready;
        logic [11:0] exp;
    } vec_t;

`ifdef AFTAB_MTVAL_WRITE_EN
    localparam int NT = 6;
`else
    localparam int NT = 5;
`endif

    step_t trap_steps[$];
    step_t mret_steps[$];
    step_t m_q[$];
    vec_t  vecs[$];

    wire [11:0] dut_v = {cntOutput, csrWrEn, csrRdEn, csrWrSrc, busy, trapDone, mretDone, instrGrant};

    function automatic logic [11:0] pack(input logic [2:0] c, input logic w, input logic r,
                                         input logic [1:0] s, input logic b, input logic t,
                                         input logic m, input logic g);
        return {c, w, r, s, b, t, m, g};
    endfunction

    function automatic step_t mk(input logic [2:0] c, input logic w, input logic r,
                                 input logic [1:0] s, input logic t, input logic m);
        step_t st;
        st.cnt = c; st.wr = w; st.rd = r; st.src = s; st.td = t; st.md = m;
        return st;
    endfunction

    function automatic logic [11:0] step_v(input step_t s);
        return pack(s.cnt, s.wr, s.rd, s.src, 1'b1, s.td, s.md, 1'b0);
    endfunction

    // Sequence in flight is a list of remaining steps; empty list means idle.
    function automatic logic [11:0] model_v();
        if (m_q.size() == 0)
            return pack(3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0,
                        ~trapReq & ~mretReq & instrCsrReq);
        return step_v(m_q[0]);
    endfunction

    always @(posedge clk) begin
        if (!rst) m_q.delete();
        else if (m_q.size() == 0) begin
            if (trapReq)      m_q = trap_steps;
            else if (mretReq) m_q = mret_steps;
        end else if (m_q[0].wr | m_q[0].rd) begin
            if (csrReady) void'(m_q.pop_front());
        end else void'(m_q.pop_front());
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic t, input logic m, input logic i, input logic c);
        rst = r; trapReq = t; mretReq = m; instrCsrReq = i; csrReady = c;
    endtask

    localparam logic [11:0] ZERO_V = 12'h000;

    initial begin
        int  cyc;
        bit  seen;
        step_t tdone_s;

        trap_steps.push_back(mk(3'b001, 1, 0, 2'b00, 0, 0));
        trap_steps.push_back(mk(3'b010, 1, 0, 2'b01, 0, 0));
`ifdef AFTAB_MTVAL_WRITE_EN
        trap_steps.push_back(mk(3'b111, 1, 0, 2'b10, 0, 0));
`endif
        trap_steps.push_back(mk(3'b100, 0, 1, 2'b00, 0, 0));
        trap_steps.push_back(mk(3'b100, 1, 0, 2'b11, 0, 0));
        trap_steps.push_back(mk(3'b011, 0, 1, 2'b00, 0, 0));
        trap_steps.push_back(mk(3'b000, 0, 0, 2'b00, 1, 0));
        mret_steps.push_back(mk(3'b100, 0, 1, 2'b00, 0, 0));
        mret_steps.push_back(mk(3'b100, 1, 0, 2'b11, 0, 0));
        mret_steps.push_back(mk(3'b010, 0, 1, 2'b00, 0, 0));
        mret_steps.push_back(mk(3'b000, 0, 0, 2'b00, 0, 1));
        tdone_s = trap_steps[NT];

        vecs.push_back('{1, 0, 1, 1, 1, pack(3'b000, 0, 0, 2'b00, 0, 0, 0, 0)});
        vecs.push_back('{1, 0, 1, 0, 1, pack(3'b100, 0, 1, 2'b00, 1, 0, 0, 0)});
        vecs.push_back('{1, 0, 1, 0, 0, pack(3'b100, 1, 0, 2'b11, 1, 0, 0, 0)});
        vecs.push_back('{1, 0, 1, 0, 1, pack(3'b100, 1, 0, 2'b11, 1, 0, 0, 0)});
        vecs.push_back('{1, 0, 0, 0, 1, pack(3'b010, 0, 1, 2'b00, 1, 0, 0, 0)});
        vecs.push_back('{1, 0, 0, 1, 1, pack(3'b000, 0, 0, 2'b00, 1, 0, 1, 0)});
        vecs.push_back('{1, 0, 0, 1, 1, pack(3'b000, 0, 0, 2'b00, 0, 0, 0, 1)});
        vecs.push_back('{1, 1, 1, 1, 1, pack(3'b000, 0, 0, 2'b00, 0, 0, 0, 0)});
        vecs.push_back('{1, 0, 1, 0, 1, pack(3'b001, 1, 0, 2'b00, 1, 0, 0, 0)});

        // Reset state
        drive(0, 0, 0, 0, 1);
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("reset_state", dut_v, ZERO_V);
        next_cyc();

        // Vector table: mret sequence with stall, grant gating, trap priority
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].trap, vecs[i].mret, vecs[i].instr, vecs[i].ready);
            @(negedge clk);
            chk($sformatf("vec%0d", i), dut_v, vecs[i].exp);
            next_cyc();
        end

        // Trap runs to completion while mret stays held, then mret is serviced
        for (int k = 1; k < NT; k++) begin
            @(negedge clk);
            chk($sformatf("trap_step%0d", k), dut_v, step_v(trap_steps[k]));
            next_cyc();
        end
        @(negedge clk);
        chk("trap_done", dut_v, step_v(tdone_s));
        next_cyc();
        @(negedge clk);
        chk("idle_after_trap", dut_v, ZERO_V);
        next_cyc();
        mretReq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("held_mret%0d", k), dut_v, step_v(mret_steps[k]));
            next_cyc();
        end
        @(negedge clk);
        chk("idle_after_mret", dut_v, ZERO_V);

        // csrReady low for 3 cycles in E_EPC stretches the sequence by 3
        drive(1, 1, 0, 0, 1);
        next_cyc();
        next_cyc();
        for (int i = 0; i < 4; i++) begin
            csrReady = (i == 3);
            @(negedge clk);
            chk($sformatf("epc_stall%0d", i), dut_v, step_v(trap_steps[1]));
            next_cyc();
        end
        csrReady = 1'b1;
        cyc = 5;
        seen = 0;
        while (!seen && cyc < 30) begin
            cyc++;
            @(negedge clk);
            if (trapDone) seen = 1;
            next_cyc();
        end
        trapReq = 1'b0;
        chk_int("stall_done_cycle", cyc, NT + 4);
        next_cyc();

        // Reset in E_STWR aborts without trapDone
        drive(1, 1, 0, 0, 1);
        next_cyc();
        for (int k = 0; k < NT - 2; k++) next_cyc();
        @(negedge clk);
        chk("at_stwr", dut_v, step_v(trap_steps[NT - 2]));
        rst = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("reset_in_stwr", dut_v, ZERO_V);
        drive(1, 0, 0, 0, 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            next_cyc();
            @(negedge clk);
            if (trapDone) seen = 1;
        end
        chk_int("no_done_after_abort", int'(seen), 0);
        next_cyc();

        // Random stimulus against the step-list model
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 59) != 0);
            trapReq     = ($urandom_range(0, 3) == 0);
            mretReq     = ($urandom_range(0, 3) == 0);
            instrCsrReq = $urandom_range(0, 1);
            csrReady    = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("random", dut_v, model_v());
            next_cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
